// File: rtl/move_search.sv
// move_search: best-placement search feeding a sub_evaluator.
// For one piece (four rotation bitmaps) it walks rotation 0..3 x column
// shift 0..COLS-1, reloads the evaluator's field copy before every
// candidate, issues one evaluation per candidate and keeps the lowest score.
// Ties keep the earliest candidate because the compare is strictly-less.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   fld_addr/data/we      game-side field row writes (accepted only while idle)
//   shapes                four 16-bit rotation bitmaps, latched on start
//   start                 begin a search (ignored while busy)
//   ev_write_*            evaluator field load
//   ev_shape, ev_shapex   candidate under evaluation
//   ev_evaluate           one-cycle evaluation request
//   ev_score, ev_busy     evaluator result / handshake
//   busy, done            search in progress / one-cycle completion pulse
//   found, best_*         search result (held until the next start)
//
// Optional feature: define MOVE_SEARCH_SKIP_DUP_EN to skip any rotation whose
// bitmap repeats a lower rotation (same result thanks to the tie rule).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; done pulses here on the cycle after NEXT
// S_SYNC    | waiting for a leftover evaluator job to finish
// S_LOAD    | copying field rows 0..ROWS-1 into the evaluator
// S_KICK    | ev_evaluate high for this one cycle
// S_WAIT_HI | waiting for ev_busy to rise
// S_WAIT_LO | waiting for ev_busy to fall, then compare ev_score
// S_NEXT    | advance (rot, x); finish after the last candidate
module move_search #(
  parameter int ROWS = 25,
  parameter int COLS = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      fld_addr,
  input  logic [COLS-1:0] fld_data,
  input  logic            fld_we,
  input  logic [63:0]     shapes,
  input  logic            start,
  output logic [4:0]      ev_write_address,
  output logic [COLS-1:0] ev_write_data,
  output logic            ev_write_enable,
  output logic [3:0]      ev_shapex,
  output logic [15:0]     ev_shape,
  output logic            ev_evaluate,
  input  logic [31:0]     ev_score,
  input  logic            ev_busy,
  output logic            busy,
  output logic            done,
  output logic            found,
  output logic [1:0]      best_rot,
  output logic [3:0]      best_x,
  output logic [31:0]     best_score
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LOAD, S_KICK, S_WAIT_HI, S_WAIT_LO, S_NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [COLS-1:0]   fld_q [ROWS];
  logic [COLS-1:0]   fld_d [ROWS];
  logic [63:0]       shapes_q, shapes_d;
  logic [1:0]        rot_q, rot_d;
  logic [3:0]        x_q, x_d;
  logic [4:0]        row_q, row_d;
  logic              busy_q, busy_d, done_q, done_d, found_q, found_d;
  logic [1:0]        best_rot_q, best_rot_d;
  logic [3:0]        best_x_q, best_x_d;
  logic [31:0]       best_score_q, best_score_d;
  logic              ev_we_q, ev_we_d, ev_eval_q, ev_eval_d;
  logic [4:0]        ev_addr_q, ev_addr_d;
  logic [COLS-1:0]   ev_data_q, ev_data_d;
  logic [15:0]       ev_shape_q, ev_shape_d;
  logic [3:0]        ev_shapex_q, ev_shapex_d;
  logic [2:0]        nxt_rot;
  logic              load_go;

`ifdef MOVE_SEARCH_SKIP_DUP_EN
  function automatic logic is_dup(input logic [63:0] s, input logic [1:0] r);
    logic d;
    d = 1'b0;
    for (int j = 0; j < 3; j++)
      if (j < int'(r) && s[6'(j * 16) +: 16] == s[{r, 4'b0000} +: 16]) d = 1'b1;
    return d;
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    fld_d        = fld_q;
    shapes_d     = shapes_q;
    rot_d        = rot_q;
    x_d          = x_q;
    row_d        = row_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    found_d      = found_q;
    best_rot_d   = best_rot_q;
    best_x_d     = best_x_q;
    best_score_d = best_score_q;
    ev_we_d      = ev_we_q;
    ev_addr_d    = ev_addr_q;
    ev_data_d    = ev_data_q;
    ev_shape_d   = ev_shape_q;
    ev_shapex_d  = ev_shapex_q;
    ev_eval_d    = 1'b0;
    nxt_rot      = '0;
    load_go      = 1'b0;

    if (!busy_q && fld_we && fld_addr <= LAST_ROW) fld_d[fld_addr] = fld_data;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shapes_d     = shapes;
          rot_d        = '0;
          x_d          = '0;
          best_score_d = '1;
          best_rot_d   = '0;
          best_x_d     = '0;
          found_d      = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_SYNC;
        end
      end
      S_SYNC: if (!ev_busy) load_go = 1'b1;
      S_LOAD: begin
        if (row_q == LAST_ROW) begin
          ev_we_d     = 1'b0;
          ev_shape_d  = shapes_q[{rot_q, 4'b0000} +: 16];
          ev_shapex_d = x_q;
          ev_eval_d   = 1'b1;
          state_d     = S_KICK;
        end else begin
          row_d     = row_q + 5'd1;
          ev_addr_d = row_q + 5'd1;
          ev_data_d = fld_q[row_q + 5'd1];
        end
      end
      S_KICK: state_d = S_WAIT_HI;
      S_WAIT_HI: if (ev_busy) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!ev_busy) begin
          if (ev_score < best_score_q) begin
            best_score_d = ev_score;
            best_rot_d   = rot_q;
            best_x_d     = x_q;
            found_d      = 1'b1;
          end
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (x_q != LAST_COL) begin
          x_d     = x_q + 4'd1;
          load_go = 1'b1;
        end else begin
          x_d     = '0;
          nxt_rot = {1'b0, rot_q} + 3'd1;
`ifdef MOVE_SEARCH_SKIP_DUP_EN
          // Repeated skip so runs of duplicate rotations are all passed over.
          for (int k = 0; k < 3; k++)
            if (!nxt_rot[2] && is_dup(shapes_q, nxt_rot[1:0])) nxt_rot = nxt_rot + 3'd1;
`endif
          if (nxt_rot[2]) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            rot_d   = nxt_rot[1:0];
            load_go = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entering LOAD presents row 0 on the same edge so each row takes one cycle.
    if (load_go) begin
      state_d   = S_LOAD;
      row_d     = '0;
      ev_we_d   = 1'b1;
      ev_addr_d = '0;
      ev_data_d = fld_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < ROWS; i++) fld_q[i] <= '0;
      shapes_q     <= '0;
      rot_q        <= '0;
      x_q          <= '0;
      row_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      best_rot_q   <= '0;
      best_x_q     <= '0;
      best_score_q <= '1;
      ev_we_q      <= 1'b0;
      ev_eval_q    <= 1'b0;
      ev_addr_q    <= '0;
      ev_data_q    <= '0;
      ev_shape_q   <= '0;
      ev_shapex_q  <= '0;
    end else begin
      state_q      <= state_d;
      fld_q        <= fld_d;
      shapes_q     <= shapes_d;
      rot_q        <= rot_d;
      x_q          <= x_d;
      row_q        <= row_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      found_q      <= found_d;
      best_rot_q   <= best_rot_d;
      best_x_q     <= best_x_d;
      best_score_q <= best_score_d;
      ev_we_q      <= ev_we_d;
      ev_eval_q    <= ev_eval_d;
      ev_addr_q    <= ev_addr_d;
      ev_data_q    <= ev_data_d;
      ev_shape_q   <= ev_shape_d;
      ev_shapex_q  <= ev_shapex_d;
    end
  end

  assign ev_write_address = ev_addr_q;
  assign ev_write_data    = ev_data_q;
  assign ev_write_enable  = ev_we_q;
  assign ev_shapex        = ev_shapex_q;
  assign ev_shape         = ev_shape_q;
  assign ev_evaluate      = ev_eval_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign found            = found_q;
  assign best_rot         = best_rot_q;
  assign best_x           = best_x_q;
  assign best_score       = best_score_q;

endmodule
